// File: rtl/gpu_cmd_pkg.sv
// Shared command-word layout for the SPI->GPU command path.
// Used by the SPI-side packer and the GPU-side reader.
package gpu_cmd_pkg;

  localparam int unsigned CMD_ADDR_WIDTH = 7;
  localparam int unsigned CMD_DATA_WIDTH = 64;
  localparam int unsigned CMD_WIDTH      = 1 + CMD_ADDR_WIDTH + CMD_DATA_WIDTH;

  localparam logic CMD_RW_READ  = 1'b1;
  localparam logic CMD_RW_WRITE = 1'b0;

  // MSB first: rw, addr, data
  typedef struct packed {
    logic                      rw;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_DATA_WIDTH-1:0] data;
  } cmd_t;

  // Assemble a command word from its fields
  function automatic cmd_t cmd_pack(input logic                      rw,
                                    input logic [CMD_ADDR_WIDTH-1:0] addr,
                                    input logic [CMD_DATA_WIDTH-1:0] data);
    cmd_t c;
    c.rw   = rw;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

endpackage

// File: rtl/cmd_skid_buf.sv
// Small circular buffer holding captured command words.
// Ports:
//   clk, rst        clock, async active-high reset (pointers/occupancy only)
//   push, push_data write push_data at the tail
//   pop             advance the head (caller guarantees occ != 0)
//   head_data       entry at the head, combinational
//   occ             number of stored entries
module cmd_skid_buf #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ_q;

  // Data array, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign occ       = occ_q;

endmodule

// File: rtl/cmd_fifo_reader.sv
// GPU-domain consumer of the SPI->GPU command async FIFO.
// Pops command words, absorbs the FIFO's one-cycle read latency through a
// local buffer, and presents rw/addr/data to the register file over
// valid/ready. Pop requests depend only on registered occupancy, never on
// cmd_ready.
// Ports:
//   clk, rst                  core clock, async active-high reset
//   enable                    allow new FIFO pops
//   fifo_rd_en/_data/_empty   async FIFO read port
//   cmd_valid/cmd_ready       command handshake to the register file
//   cmd_rw/cmd_addr/cmd_wdata decoded head command
//   idle                      nothing buffered and nothing in flight
//   cmd_count                 commands accepted since reset
module cmd_fifo_reader #(
  parameter int unsigned CMD_WIDTH  = gpu_cmd_pkg::CMD_WIDTH,
  parameter int unsigned ADDR_WIDTH = gpu_cmd_pkg::CMD_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = gpu_cmd_pkg::CMD_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [CMD_WIDTH-1:0]  fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_rw,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  idle,
  output logic [31:0]           cmd_count
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  // Reject inconsistent configurations at elaboration
  if (CMD_WIDTH != 1 + ADDR_WIDTH + DATA_WIDTH) begin : g_bad_width
    $fatal(1, "cmd_fifo_reader: CMD_WIDTH must equal 1+ADDR_WIDTH+DATA_WIDTH");
  end
  if (BUF_DEPTH < 3 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "cmd_fifo_reader: BUF_DEPTH must be a power of two >= 3");
  end

  logic [OCC_W-1:0]     occ;
  logic [CMD_WIDTH-1:0] head;
  logic                 inflight_q;
  logic [31:0]          count_q;
  logic                 credit;
  logic                 pop;
  logic                 accept;

  // Room for one more word counting the one already in flight
  assign credit     = (occ + OCC_W'(inflight_q)) < OCC_W'(BUF_DEPTH);
  assign fifo_rd_en = !rst && enable && !fifo_rd_empty && credit;
  assign pop        = fifo_rd_en && !fifo_rd_empty;

  assign cmd_valid  = (occ != '0);
  assign accept     = cmd_valid && cmd_ready;
  assign idle       = (occ == '0) && !inflight_q;

  assign cmd_rw     = head[CMD_WIDTH-1];
  assign cmd_addr   = head[CMD_WIDTH-2 -: ADDR_WIDTH];
  assign cmd_wdata  = head[DATA_WIDTH-1:0];
  assign cmd_count  = count_q;

  // Read data is valid exactly one cycle after an accepted pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      inflight_q <= pop;
      if (accept) count_q <= count_q + 32'd1;
    end
  end

  cmd_skid_buf #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (accept),
    .head_data (head),
    .occ       (occ)
  );

endmodule

// File: tb/tb_cmd_fifo_reader.sv
// Directed bench for cmd_fifo_reader with a behavioural async-FIFO read port.
module tb_cmd_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_rd_en;
  logic [71:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic        idle;
  logic [31:0] cmd_count;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [71:0] fq[$];
  logic [71:0] expq[$];
  logic [71:0] rx[$];

  always #5 clk = ~clk;

  // FIFO read port: registered data, one cycle after an accepted pop
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_rd_empty && fq.size() > 0)
      fifo_rd_data <= fq.pop_front();
  end

  cmd_fifo_reader dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rw        (cmd_rw),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .idle          (idle),
    .cmd_count     (cmd_count)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic rw, input logic [6:0] a, input logic [63:0] d);
    return {rw, a, d};
  endfunction

  // Apply inputs for this cycle and record what the coming edge will do
  task automatic drive(input logic rdy, input logic en);
    cmd_ready     = rdy;
    enable        = en;
    fifo_rd_empty = (fq.size() == 0);
    #1;
    if (cmd_valid && cmd_ready) rx.push_back({cmd_rw, cmd_addr, cmd_wdata});
    if (fifo_rd_en) pops++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int order_errors(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rx.size() || i >= expq.size()) bad++;
      else if (rx[i] !== expq[i]) bad++;
    end
    return bad;
  endfunction

  initial begin
    int first_v;
    int last_v;
    int vcycles;
    int unstable;
    logic [71:0] w;

    // Reset: request lines must stay quiet even with data available
    rst = 1'b1; enable = 1'b1; cmd_ready = 1'b0; fifo_rd_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 72'(fifo_rd_en), 72'(1'b0));
    chk("rst_valid", 72'(cmd_valid), 72'(1'b0));
    chk("rst_idle", 72'(idle), 72'(1'b1));
    chk("rst_count", 72'(cmd_count), 72'(32'd0));
    fifo_rd_empty = 1'b1;
    rst = 1'b0;
    step();

    // Single command
    w = 72'h1A_0000_0000_DEAD_BEEF;
    fq.push_back(w); pops = 0; rx.delete();
    drive(1'b1, 1'b1);
    chk("t1_rd_en_pulse", 72'(fifo_rd_en), 72'(1'b1));
    step();
    drive(1'b1, 1'b1);
    chk("t1_rd_en_off", 72'(fifo_rd_en), 72'(1'b0));
    chk("t1_valid_n1", 72'(cmd_valid), 72'(1'b0));
    chk("t1_idle_busy", 72'(idle), 72'(1'b0));
    step();
    drive(1'b1, 1'b1);
    chk("t1_valid_n2", 72'(cmd_valid), 72'(1'b1));
    chk("t1_rw", 72'(cmd_rw), 72'(1'b0));
    chk("t1_addr", 72'(cmd_addr), 72'(7'h1A));
    chk("t1_wdata", 72'(cmd_wdata), 72'(64'hDEAD_BEEF));
    step();
    drive(1'b1, 1'b1);
    chk("t1_valid_end", 72'(cmd_valid), 72'(1'b0));
    chk("t1_idle_end", 72'(idle), 72'(1'b1));
    chk("t1_count", 72'(cmd_count), 72'(32'd1));
    chk("t1_pops", 72'(pops), 72'(1));
    step();

    // Burst of 16 with ready held high
    expq.delete(); rx.delete(); pops = 0;
    for (int i = 0; i < 16; i++) begin
      w = mk(1'(i % 2), 7'(i + 3), 64'h1000_0000_0000_0000 + 64'(i * 7));
      fq.push_back(w); expq.push_back(w);
    end
    first_v = -1; last_v = -1; vcycles = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 1'b1);
      if (cmd_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        vcycles++;
      end
      step();
    end
    chk("t2_latency", 72'(first_v), 72'(2));
    chk("t2_valid_cycles", 72'(vcycles), 72'(16));
    chk("t2_no_gaps", 72'(last_v - first_v + 1), 72'(16));
    chk("t2_order", 72'(order_errors(16)), 72'(0));
    chk("t2_count", 72'(cmd_count), 72'(32'd17));

    // Backpressure: ten commands, ready low for 20 cycles
    expq.delete(); rx.delete(); pops = 0;
    for (int i = 0; i < 10; i++) begin
      w = mk(1'(i > 4), 7'(7'h40 + 7'(i)), 64'hCAFE_0000_0000_0000 | 64'(i));
      fq.push_back(w); expq.push_back(w);
    end
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1);
      if (cmd_valid && {cmd_rw, cmd_addr, cmd_wdata} !== expq[0]) unstable++;
      step();
    end
    drive(1'b0, 1'b1);
    chk("t3_pops_held", 72'(pops), 72'(4));
    chk("t3_rd_en_full", 72'(fifo_rd_en), 72'(1'b0));
    chk("t3_valid_held", 72'(cmd_valid), 72'(1'b1));
    chk("t3_fields_stable", 72'(unstable), 72'(0));
    chk("t3_head", {cmd_rw, cmd_addr, cmd_wdata}, expq[0]);
    step();
    for (int c = 0; c < 60 && rx.size() < 10; c++) begin
      drive(1'b1, 1'b1);
      step();
    end
    drive(1'b1, 1'b1);
    chk("t3_delivered", 72'(rx.size()), 72'(10));
    chk("t3_order", 72'(order_errors(10)), 72'(0));
    chk("t3_pops_total", 72'(pops), 72'(10));
    chk("t3_count", 72'(cmd_count), 72'(32'd27));
    step();

    // Enable drops right after a pop is accepted
    expq.delete(); rx.delete(); pops = 0;
    for (int i = 0; i < 3; i++) begin
      w = mk(1'b1, 7'(7'h10 + 7'(i)), 64'h0BAD_F00D_0000_0000 + 64'(i));
      fq.push_back(w); expq.push_back(w);
    end
    drive(1'b1, 1'b1);
    chk("t4_rd_en", 72'(fifo_rd_en), 72'(1'b1));
    step();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0);
      step();
    end
    drive(1'b1, 1'b0);
    chk("t4_pops", 72'(pops), 72'(1));
    chk("t4_delivered", 72'(rx.size()), 72'(1));
    chk("t4_word", rx.size() > 0 ? rx[0] : 72'h0, expq[0]);
    chk("t4_fifo_left", 72'(fq.size()), 72'(2));
    chk("t4_idle", 72'(idle), 72'(1'b1));
    chk("t4_count", 72'(cmd_count), 72'(32'd28));
    fq.delete();
    step();

    // Reset with three commands buffered
    rx.delete(); pops = 0;
    for (int i = 0; i < 3; i++) fq.push_back(mk(1'b0, 7'(i), 64'(i + 100)));
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1);
      step();
    end
    chk("t5_pops", 72'(pops), 72'(3));
    fq.push_back(mk(1'b0, 7'h7F, 64'h1));
    drive(1'b0, 1'b1);
    chk("t5_pre_valid", 72'(cmd_valid), 72'(1'b1));
    chk("t5_pre_rd_en", 72'(fifo_rd_en), 72'(1'b1));
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 72'(cmd_valid), 72'(1'b0));
    chk("t5_rst_rd_en", 72'(fifo_rd_en), 72'(1'b0));
    chk("t5_rst_count", 72'(cmd_count), 72'(32'd0));
    chk("t5_rst_idle", 72'(idle), 72'(1'b1));
    fq.delete();
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1);
    chk("t5_post_valid", 72'(cmd_valid), 72'(1'b0));
    step();

    // Counter wrap
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    rx.delete();
    for (int i = 0; i < 3; i++) fq.push_back(mk(1'b1, 7'(i + 1), 64'(i)));
    for (int c = 0; c < 20 && rx.size() < 3; c++) begin
      drive(1'b1, 1'b1);
      step();
    end
    drive(1'b1, 1'b1);
    chk("t6_delivered", 72'(rx.size()), 72'(3));
    chk("t6_count_wrap", 72'(cmd_count), 72'(32'h0000_0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_fifo_reader.md
Name: cmd_fifo_reader

Overview:
- Read-side consumer for the SPI→GPU command async_fifo; lives entirely in the GPU core clock domain.
- Pops 72-bit command words, absorbing the FIFO's one-cycle registered read latency.
- Splits each word into rw/addr/data and presents it to the register file over a valid/ready handshake.
- A small local buffer gives one command per cycle with no combinational path from cmd_ready to fifo_rd_en.

Parameters:
- CMD_WIDTH, 72, FIFO word width; must equal 1 + ADDR_WIDTH + DATA_WIDTH.
- ADDR_WIDTH, 7, register address width.
- DATA_WIDTH, 64, register data width.
- BUF_DEPTH, 4, local buffer entries; power of 2, minimum 3.

Ports:
- clk  in  1  core clock; the block's only clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  when 0, no new FIFO pops are issued; the local buffer keeps draining.
- fifo_rd_en  out  1  pop request to the async FIFO read port.
- fifo_rd_data  in  CMD_WIDTH  FIFO read data; valid in the cycle after an accepted pop.
- fifo_rd_empty  in  1  FIFO empty flag.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  register file accepts the command.
- cmd_rw  out  1  fifo word bit [CMD_WIDTH-1]; 1 = read, 0 = write.
- cmd_addr  out  ADDR_WIDTH  bits [CMD_WIDTH-2 : DATA_WIDTH].
- cmd_wdata  out  DATA_WIDTH  bits [DATA_WIDTH-1 : 0].
- idle  out  1  no command buffered and none in flight.
- cmd_count  out  32  total commands accepted since reset.

Behaviour:
- Reset (async, active-high) clears pointers, occupancy, inflight and cmd_count to 0.
  - Outputs while in reset: fifo_rd_en=0, cmd_valid=0, idle=1, cmd_count=0.
  - Buffer data RAM is not reset.
- pop = fifo_rd_en && !fifo_rd_empty.
  - fifo_rd_en = enable && !fifo_rd_empty && (occ + inflight < BUF_DEPTH).
  - occ and inflight are registered values only; cmd_ready never feeds fifo_rd_en.
- inflight register: next value = pop.
  - When inflight=1, fifo_rd_data is written at the tail and the tail pointer increments with wrap.
  - Data is captured exactly one cycle after the pop; fifo_rd_data is never sampled otherwise, since it is X before the first pop.
- Output side:
  - cmd_valid = (occ != 0); the cmd_* fields decode combinationally from the head entry.
  - Accept = cmd_valid && cmd_ready; on accept the head pointer increments with wrap.
  - cmd_* fields must stay stable while cmd_valid=1 and cmd_ready=0.
- Occupancy update:
  - occ_next = occ + inflight − accept.
  - Capture and accept in the same cycle leave occ unchanged.
  - Accept with occ=1 and capture in the same cycle: the captured entry becomes the head next cycle, with no bubble.
- Throughput:
  - Sustained 1 command/cycle once primed, with BUF_DEPTH ≥ 3.
  - First-command latency: pop in cycle N, cmd_valid in cycle N+2.
- Full buffer: when occ + inflight == BUF_DEPTH, fifo_rd_en=0; pops resume the cycle after an accept.
- Empty FIFO: fifo_rd_en=0; the buffer drains normally.
- enable deasserted mid-burst:
  - No new pops.
  - An in-flight word is still captured.
  - Buffered commands are still delivered.
- idle = (occ == 0) && !inflight.
- cmd_count increments on accept; wraps 0xFFFF_FFFF → 0.
- Reset mid-operation:
  - Buffered and in-flight commands are discarded.
  - System integration asserts the FIFO rd_rst_n together with rst, so pointers stay consistent.
- Illegal parameters: CMD_WIDTH ≠ 1+ADDR_WIDTH+DATA_WIDTH, or BUF_DEPTH < 3, is a fatal elaboration error.

Decomposition:
- Package gpu_cmd_pkg:
  - localparams CMD_WIDTH, CMD_ADDR_WIDTH, CMD_DATA_WIDTH.
  - typedef cmd_t packed struct {rw, addr, data}.
  - CMD_RW_READ/CMD_RW_WRITE constants.
  - Shared with the SPI-side command packer.
- Sub-module cmd_skid_buf: synchronous BUF_DEPTH-entry buffer with push/pop/occ, no reset on the data array.
- The top level holds the pop/credit/inflight logic and the counter.

Test Plan:
- Single command: FIFO holds 0x0_1A_0000_0000_DEAD_BEEF, cmd_ready=1.
  - Required: fifo_rd_en pulses for 1 cycle.
  - Two cycles later: cmd_valid=1, rw=0, addr=0x1A, wdata=0xDEADBEEF for one cycle.
  - cmd_count=1; idle returns to 1.
- Burst of 16, cmd_ready=1 throughout → 16 consecutive cmd_valid cycles, in order, no gaps after priming; cmd_count=16.
- Backpressure: 10 commands, cmd_ready=0 for 20 cycles.
  - Required: exactly 4 pops, then fifo_rd_en=0; fields stable.
  - Release: all 10 delivered in order; no loss or duplication.
- enable dropped the same cycle a pop is accepted → the in-flight word is still delivered; no further pops; idle=1 after drain.
- Reset asserted with 3 buffered commands → cmd_valid=0 and fifo_rd_en=0 immediately (async); cmd_count=0; idle=1.
- cmd_count preloaded near wrap via force to 0xFFFF_FFFE, then 3 accepts → final value 0x0000_0001.
